// File: rtl/fma_issue_arbiter.sv
// fma_issue_arbiter
//   Shares one pipelined recoded single-precision FMA unit among NUM_REQ
//   vector-lane requesters. Round-robin grant (one issue per cycle), a
//   registered issue stage driving the FMA inputs, and a tag pipeline that
//   remembers which requester owns each in-flight op so the result can be
//   steered back to it.
//
// Ports
//   clock, reset        clock; synchronous active-high reset
//   enable              low blocks new grants; in-flight ops still finish
//   req_valid/req_ready per-requester handshake (ready is one-hot or zero)
//   req_op/a/b/c/rm     per-requester packed operands, lane i at slice i
//   fma_valid/op/a/b/c/rm  registered drive of the shared FMA inputs
//   fma_out/fma_flags   FMA result, valid LATENCY cycles after fma_valid
//   resp_valid          one-hot result strobe to the owning requester
//   resp_out/resp_flags shared result/flag bus (passthrough of the FMA)
//   idle                nothing in flight and issue register empty
module fma_issue_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned ID_W    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [2*NUM_REQ-1:0]  req_op,
  input  logic [33*NUM_REQ-1:0] req_a,
  input  logic [33*NUM_REQ-1:0] req_b,
  input  logic [33*NUM_REQ-1:0] req_c,
  input  logic [3*NUM_REQ-1:0]  req_rm,
  output logic                  fma_valid,
  output logic [1:0]            fma_op,
  output logic [32:0]           fma_a,
  output logic [32:0]           fma_b,
  output logic [32:0]           fma_c,
  output logic [2:0]            fma_rm,
  input  logic [32:0]           fma_out,
  input  logic [4:0]            fma_flags,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [32:0]           resp_out,
  output logic [4:0]            resp_flags,
  output logic                  idle
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 2);

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  grantIdx;
  logic             grantAny;
  logic             grant;
  logic             issueValid;
  logic [ID_W-1:0]  issueId;
  logic             tagValid [LATENCY];
  logic [ID_W-1:0]  tagId    [LATENCY];
  logic             tagAny;
  logic             respFire;
  logic [CNT_W-1:0] inflight;

  // Scan priority order ptr, ptr+1, ... (mod NUM_REQ); first valid wins.
  always_comb begin
    cand     = '0;
    grantIdx = '0;
    grantAny = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      cand = ID_W'((32'(ptr) + j) % NUM_REQ);
      if (!grantAny && req_valid[cand]) begin
        grantAny = 1'b1;
        grantIdx = cand;
      end
    end
  end

  assign grant = grantAny && enable && !reset;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[grantIdx] = 1'b1;
  end

  // Control state: pointer, valid bits and in-flight counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr        <= '0;
      issueValid <= 1'b0;
      inflight   <= '0;
      for (int unsigned k = 0; k < LATENCY; k++) tagValid[k] <= 1'b0;
    end else begin
      issueValid  <= grant;
      tagValid[0] <= issueValid;
      for (int unsigned k = 1; k < LATENCY; k++) tagValid[k] <= tagValid[k-1];
      if (grant)
        ptr <= (grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
      if (grant && !respFire)
        inflight <= inflight + 1'b1;
      else if (!grant && respFire)
        inflight <= inflight - 1'b1;
    end
  end

  // Datapath registers need no reset; their contents are qualified by the
  // valid bits above.
  always_ff @(posedge clock) begin
    if (grant) begin
      issueId <= grantIdx;
      fma_op  <= req_op[2*32'(grantIdx) +: 2];
      fma_a   <= req_a[33*32'(grantIdx) +: 33];
      fma_b   <= req_b[33*32'(grantIdx) +: 33];
      fma_c   <= req_c[33*32'(grantIdx) +: 33];
      fma_rm  <= req_rm[3*32'(grantIdx) +: 3];
    end
    tagId[0] <= issueId;
    for (int unsigned k = 1; k < LATENCY; k++) tagId[k] <= tagId[k-1];
  end

  assign fma_valid = issueValid;
  assign respFire  = tagValid[LATENCY-1];

  always_comb begin
    resp_valid = '0;
    if (respFire) resp_valid[tagId[LATENCY-1]] = 1'b1;
  end

  assign resp_out   = fma_out;
  assign resp_flags = fma_flags;

  always_comb begin
    tagAny = 1'b0;
    for (int unsigned k = 0; k < LATENCY; k++) tagAny = tagAny | tagValid[k];
  end

  assign idle = (inflight == '0);

  // The counter and the valid bits are two views of the same occupancy.
  always_ff @(posedge clock) begin
    if (!reset) assert (idle == (!issueValid && !tagAny));
  end

endmodule
